// File: rtl/pattern_sequencer.sv
// Serial pattern sequencer: shifts a captured pattern out MSB-first,
// repeated a captured number of times with an idle gap between passes.
module pattern_sequencer #(
    parameter int WIDTH      = 8,
    parameter int REP_W      = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [WIDTH-1:0]         pattern,
    input  logic [REP_W-1:0]         reps,
    input  logic                     abort,
    output logic                     y,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(WIDTH)-1:0] bit_idx
);

    localparam int IW = $clog2(WIDTH);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST =
        GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_pat;
    logic [REP_W-1:0] r_rem;
    logic [GW-1:0]    r_gap;

    logic [IW-1:0]    w_nidx;
    logic [REP_W-1:0] w_rem_dec;

    assign w_nidx    = bit_idx + 1'b1;
    assign w_rem_dec = r_rem - 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pat   <= '0;
            r_rem   <= '0;
            r_gap   <= '0;
            y       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bit_idx <= '0;
        end else if (abort && r_state != S_IDLE) begin
            r_state <= S_IDLE;
            y       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bit_idx <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    // abort in IDLE swallows a simultaneous start
                    if (start && !abort) begin
                        if (reps != '0) begin
                            r_pat   <= pattern;
                            r_rem   <= reps;
                            r_state <= S_SHIFT;
                            y       <= pattern[WIDTH-1];
                            busy    <= 1'b1;
                            bit_idx <= '0;
                        end else begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    if (bit_idx != LAST_IDX) begin
                        bit_idx <= w_nidx;
                        y       <= r_pat[LAST_IDX - w_nidx];
                    end else begin
                        r_rem   <= w_rem_dec;
                        bit_idx <= '0;
                        if (w_rem_dec == '0) begin
                            r_state <= S_DONE;
                            y       <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else if (GAP_CYCLES > 0) begin
                            r_state <= S_GAP;
                            r_gap   <= '0;
                            y       <= 1'b0;
                        end else begin
                            y <= r_pat[WIDTH-1];
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        r_state <= S_SHIFT;
                        y       <= r_pat[WIDTH-1];
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pattern_sequencer.md
Name: pattern_sequencer

Overview:
Controller that drives the serial output `y` of the pattern-generator datapath. It captures an N-bit pattern and a repeat count on a start request, then shifts the pattern out MSB-first the requested number of times, with a fixed idle gap between repetitions. It reports `busy` during operation and pulses `done` on completion. It sits between the activity top level (switch/button inputs) and the serial output pin.

Parameters:
WIDTH, 8, pattern length in bits (≥2)
REP_W, 4, width of repeat-count input
GAP_CYCLES, 2, cycles of y=0 inserted between repetitions (0 = back-to-back)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  start request, sampled only in IDLE
pattern  input  WIDTH  pattern to transmit, captured on accepted start
reps  input  REP_W  number of repetitions, captured on accepted start
abort  input  1  synchronous abort, priority over all but reset
y  output  1  serial pattern output, registered
busy  output  1  high while transmitting or in gap
done  output  1  one-cycle completion pulse
bit_idx  output  $clog2(WIDTH)  index of bit currently on y (0 = MSB), 0 when idle

Behaviour:
- Reset (rst_n=0, async):
  - State = IDLE.
  - y=0, busy=0, done=0, bit_idx=0.
  - Internal pattern register, remaining-reps count, and gap count are all cleared.
- States: IDLE, SHIFT, GAP, DONE. All outputs are registered.
- IDLE:
  - start=1 and reps≠0:
    - Capture pattern and reps; remaining = reps.
    - Next state = SHIFT.
    - In the following cycle, y = pattern[WIDTH-1], busy=1, bit_idx=0.
  - start=1 and reps=0: next state = DONE. No bits are output and busy stays 0.
- SHIFT:
  - Each cycle presents the next lower bit; bit_idx increments.
  - After bit 0 has been presented for one cycle, remaining decrements.
  - If remaining (after decrement) > 0:
    - GAP_CYCLES > 0: go to GAP.
    - GAP_CYCLES = 0: present MSB again in the next cycle.
  - Otherwise go to DONE.
- GAP:
  - y=0, busy=1, bit_idx=0 for exactly GAP_CYCLES cycles.
  - Then go to SHIFT with y = MSB.
- DONE: for one cycle, done=1, busy=0, y=0. Then return to IDLE.
- start is ignored in SHIFT, GAP and DONE. Changes to pattern or reps after capture have no effect.
- Latency: accepted start at edge k → first bit valid in cycle k+1. Total busy cycles = reps·WIDTH + (reps−1)·GAP_CYCLES.
- abort=1 in SHIFT, GAP or DONE:
  - Next cycle: IDLE, y=0, busy=0, done=0 (no done pulse).
  - abort in IDLE has no effect. If abort and start are both high in IDLE, abort wins and start is dropped.
- Reset asserted mid-operation: outputs clear immediately (asynchronously). After release, the block waits in IDLE for a new start.
- Counters never wrap:
  - remaining counts down from reps to 0 and stops.
  - bit_idx range is 0..WIDTH-1.

Test Plan:
1. WIDTH=8, start with pattern=8'hA5, reps=1, accepted at edge 0 → y in cycles 1–8 = 1,0,1,0,0,1,0,1; busy=1 in cycles 1–8; done=1 only in cycle 9; y=0 afterwards.
2. pattern=8'hF0, reps=2, GAP_CYCLES=2 → cycles 1–8 = 11110000; cycles 9–10 y=0 with busy=1; cycles 11–18 = 11110000; done pulse in cycle 19.
3. reps=0, start at edge 0 → done=1 in cycle 1; busy and y stay 0 throughout.
4. pattern=8'hA5, reps=3; abort high for edge 4 → y=0 and busy=0 from cycle 5; no done pulse; a new start is accepted from cycle 5.
5. During a pattern=8'hA5 transfer, pulse start with pattern=8'h00 at cycle 3 → output stream unchanged (10100101); exactly one done pulse.
6. Drive rst_n low asynchronously mid-cycle 6 of a transfer → y, busy and done go to 0 without waiting for a clock edge; after release, outputs stay idle until the next start.
